seq_chunk_adder_sub: RTL and testbench
======================================

// Module: seq_chunk_adder_sub
// PURPOSE
//  - Parametrised multi-cycle add/subtract/accumulate unit. Successor to the 4-bit ripple full adder.
//  - Processes a WIDTH-bit operand pair in CHUNK-bit slices, LSB slice first, one slice per clock.
//  - The carry is held in a register between slices.
//  - Valid/ready handshake on both the input and the output side. Sits between the operand source and the result sink in datapath labs.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of CHUNK
//  CHUNK   4  bits per cycle; NCHUNK = WIDTH/CHUNK; CHUNK==WIDTH is legal (single-slice case)
// PORTS
//  CLK        in   1      rising-edge clock
//  RST_N      in   1      reset; synchronous, active-low
//  IN_VALID   in   1      operand request present
//  IN_READY   out  1      unit can accept an operand request
//  MODE       in   2      00 ADD, 01 SUB, 10 ACC, 11 CLR
//  C0         in   1      carry-in (ADD, ACC only)
//  X          in   WIDTH  operand A
//  Y          in   WIDTH  operand B (ADD, SUB only)
//  OUT_VALID  out  1      result valid
//  OUT_READY  in   1      sink accepts the result
//  S          out  WIDTH  result
//  CN         out  1      carry-out of the MSB (SUB: 1 = no borrow)
//  OVF        out  1      signed overflow = carry into MSB ^ carry out of MSB
//  ZERO       out  1      S == 0
// BEHAVIOUR
//  Reset (RST_N==0 at an edge):
//  - state=IDLE, IN_READY=1, OUT_VALID=0, S=0, CN=0, OVF=0, ZERO=0.
//  - Accumulator ACC=0, slice counter=0.
//  - Applies from any state. An in-flight operation is discarded with no output.
//  States IDLE -> RUN -> DONE -> IDLE:
//  - IDLE: IN_READY=1. On an edge with IN_VALID=1, latch MODE/C0/X/Y, set carry register, set cnt=0, go to RUN.
//  - RUN: IN_READY=0. Each edge computes slice cnt into S[cnt*CHUNK +: CHUNK] and updates the carry register.
//    - When cnt==NCHUNK-1: latch CN/OVF/ZERO, set OUT_VALID=1, go to DONE. Otherwise cnt++.
//  - DONE: OUT_VALID=1. S and flags are held stable while OUT_READY=0. On an edge with OUT_READY=1: OUT_VALID=0, go to IDLE.
//  - IN_VALID is ignored outside IDLE. No overlap: the next accept happens at the earliest 1 cycle after the result is consumed.
//  Latency:
//  - OUT_VALID rises NCHUNK edges after the accept edge (16/4 -> 4).
//  - Throughput is 1 result per NCHUNK+2 cycles when OUT_READY is held high.
//  Operand setup per mode (carry register init / B-operand):
//  - ADD: A=X, B=Y, cin=C0.
//  - SUB: A=X, B=~Y, cin=1. C0 is ignored.
//  - ACC: A=ACC, B=X, cin=C0. ACC <= S on the edge entering DONE.
//  - CLR: A=0, B=0, cin=0. Result S=0, ZERO=1, CN=0, OVF=0. ACC <= 0 on the edge entering DONE.
//  Arithmetic rules:
//  - All arithmetic is modulo 2^WIDTH. CN is the carry out of bit WIDTH-1.
//  - OVF uses the carry into bit WIDTH-1, i.e. the MSB-position carry of the last slice.
//  - S bits above the current slice are not guaranteed while in RUN. They are only valid when OUT_VALID=1.
//  - Outputs CN/OVF/ZERO are registered; they change only on the edge entering DONE or on reset.
// STRUCTURE
//  - Shared package adder_pkg holds:
//    - MODE_ADD/MODE_SUB/MODE_ACC/MODE_CLR 2-bit constants;
//    - state encoding ST_IDLE/ST_RUN/ST_DONE;
//    - a width-check helper (WIDTH % CHUNK == 0).
//  - Sub-module chunk_adder #(CHUNK): combinational CHUNK-bit ripple adder.
//    - Inputs: a, b, cin. Outputs: s, cout, c_msb (the carry into its top bit).
//    - Instanced once; the top handles slice selection, registers and the FSM.
//  - The top elaborates an error if WIDTH % CHUNK != 0.
// TESTING  (WIDTH=16, CHUNK=4 unless noted)
//  1. ADD X=00FF Y=0001 C0=0 -> S=0100 CN=0 OVF=0 ZERO=0. OUT_VALID exactly 4 edges after accept.
//  2. ADD 7FFF+0001 -> S=8000 OVF=1 CN=0.
//     ADD FFFF+0000 with C0=1 -> S=0000 CN=1 ZERO=1 OVF=0.
//  3. SUB 0003-0005 -> S=FFFE CN=0 OVF=0.
//     SUB 8000-0001 -> S=7FFF CN=1 OVF=1.
//  4. Sequence CLR; ACC X=1234 C0=0; ACC X=0001 C0=1.
//     -> S=0000, then 1234, then 1236. A further ADD leaves ACC unchanged.
//  5. Hold OUT_READY=0 for 5 cycles in DONE while toggling IN_VALID/X.
//     -> S and flags stable, IN_READY=0.
//     Release -> OUT_VALID drops, IN_READY=1 on the next cycle.
//  6. RST_N=0 at the 2nd RUN edge -> next cycle all outputs 0, IN_READY=1.
//     A following ACC X=0001 returns 0001 (ACC was cleared).
//     Repeat case 1 with CHUNK=16 -> latency 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants, FSM encoding and parameter check for the chunked adder.
// Pure definitions; no latency, no backpressure.
package adder_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic width_ok(input int w, input int c);
        return (c > 0) && ((w % c) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder exposing the carry into its top bit.
// Zero latency; no flow control.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder_sub.sv
// Multi-cycle add/sub/accumulate, one CHUNK slice per clock, LSB slice first.
// Result valid NCHUNK edges after accept; result and flags held while OUT_READY is low.
module seq_chunk_adder_sub
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       MODE,
    input  logic             C0,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CN,
    output logic             OVF,
    output logic             ZERO
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("seq_chunk_adder_sub: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d, acc_q, acc_d;
    logic             cn_q, cn_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] sum_sl;
    logic             sl_cout, sl_cmsb;

    assign idx = IDX_W'(32'(cnt_q) * CHUNK);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[idx +: CHUNK]),
        .b     (b_q[idx +: CHUNK]),
        .cin   (carry_q),
        .s     (sum_sl),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        acc_d   = acc_q;
        cn_d    = cn_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    mode_d  = MODE;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    unique case (MODE)
                        MODE_ADD: begin a_d = X;     b_d = Y;     carry_d = C0;   end
                        MODE_SUB: begin a_d = X;     b_d = ~Y;    carry_d = 1'b1; end
                        MODE_ACC: begin a_d = acc_q; b_d = X;     carry_d = C0;   end
                        default:  begin a_d = '0;    b_d = '0;    carry_d = 1'b0; end
                    endcase
                end
            end
            ST_RUN: begin
                s_d[idx +: CHUNK] = sum_sl;
                carry_d           = sl_cout;
                if (cnt_q == LAST) begin
                    cn_d    = sl_cout;
                    ovf_d   = sl_cout ^ sl_cmsb;
                    zero_d  = (s_d == '0);
                    state_d = ST_DONE;
                    if (mode_q == MODE_ACC) acc_d = s_d;
                    if (mode_q == MODE_CLR) acc_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (OUT_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_ADD;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            acc_q   <= '0;
            cn_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
            cn_q    <= cn_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_DONE);
    assign S         = s_q;
    assign CN        = cn_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_seq_chunk_adder_sub.sv
// Directed bench for seq_chunk_adder_sub: 16/4 instance plus a 16/16 single-slice instance.
module tb_seq_chunk_adder_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid1;
    logic        out_ready, out_ready1;
    logic [1:0]  mode;
    logic        c0;
    logic [15:0] x, y;

    logic        in_ready, out_valid, cn, ovf, zero;
    logic [15:0] s;
    logic        in_ready1, out_valid1, cn1, ovf1, zero1;
    logic [15:0] s1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_chunk_adder_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .MODE(mode), .C0(c0), .X(x), .Y(y),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .S(s), .CN(cn), .OVF(ovf), .ZERO(zero)
    );

    seq_chunk_adder_sub #(.WIDTH(16), .CHUNK(16)) dut1 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid1), .IN_READY(in_ready1),
        .MODE(mode), .C0(c0), .X(x), .Y(y),
        .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
        .S(s1), .CN(cn1), .OVF(ovf1), .ZERO(zero1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request in IDLE; returns #1 after the accept edge.
    task automatic start_op(input string tag, input logic [1:0] m, input logic cin,
                            input logic [15:0] xa, input logic [15:0] ya);
        @(negedge clk);
        mode = m; c0 = cin; x = xa; y = ya; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_result(input string tag, input logic [15:0] es,
                                input logic ecn, input logic eovf, input logic ezero);
        chk({tag, "_s"},    32'(s),    32'(es));
        chk({tag, "_cn"},   32'(cn),   32'(ecn));
        chk({tag, "_ovf"},  32'(ovf),  32'(eovf));
        chk({tag, "_zero"}, 32'(zero), 32'(ezero));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(in_ready),  32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic cin,
                          input logic [15:0] xa, input logic [15:0] ya,
                          input logic [15:0] es, input logic ecn, input logic eovf,
                          input logic ezero);
        start_op(tag, m, cin, xa, ya);
        wait_done(tag, 4);
        check_result(tag, es, ecn, eovf, ezero);
        consume(tag);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
        out_ready = 1'b0; out_ready1 = 1'b0;
        mode = 2'b00; c0 = 1'b0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add and carry/overflow corners
        run_op("add_ff_1",   2'b00, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf",    2'b00, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("add_wrap",   2'b00, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_neg",    2'b01, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",    2'b01, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Accumulator sequence; an ADD must not disturb ACC
        run_op("clr",        2'b11, 1'b1, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("acc_1234",   2'b10, 1'b0, 16'h1234, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0);
        run_op("acc_plus2",  2'b10, 1'b1, 16'h0001, 16'h0000, 16'h1236, 1'b0, 1'b0, 1'b0);
        run_op("add_mid",    2'b00, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op("acc_keep",   2'b10, 1'b0, 16'h0000, 16'h0000, 16'h1236, 1'b0, 1'b0, 1'b0);

        // Backpressure: result frozen while sink stalls, new requests ignored
        start_op("stall", 2'b00, 1'b0, 16'h1111, 16'h2222);
        wait_done("stall", 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            x = 16'hF0F0 ^ 16'(i);
            @(posedge clk); #1;
            chk("stall_s", 32'(s), 32'h3333);
            chk("stall_flags", {29'd0, cn, ovf, zero}, 32'd0);
            chk("stall_vld", 32'(out_valid), 32'd1);
            chk("stall_in_rdy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_rel_vld", 32'(out_valid), 32'd0);
        chk("stall_rel_rdy", 32'(in_ready), 32'd1);

        // Reset sampled at the second RUN edge discards the operation
        start_op("rst_run", 2'b00, 1'b0, 16'h1234, 16'h1111);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_run_in_rdy", 32'(in_ready), 32'd1);
        chk("rst_run_vld", 32'(out_valid), 32'd0);
        check_result("rst_run", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("acc_after_rst", 2'b10, 1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);

        // Single-slice instance: one edge of latency
        @(negedge clk);
        mode = 2'b00; c0 = 1'b0; x = 16'h00FF; y = 16'h0001; in_valid1 = 1'b1;
        chk("w16_in_rdy", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w16_latency", 32'(lat), 32'd1);
        chk("w16_s", 32'(s1), 32'h0100);
        chk("w16_flags", {29'd0, cn1, ovf1, zero1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
